// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: datapath widths, the NOP encoding and
// the IF/ID pipeline bundle.
package arm_pkg;

    localparam int          WORD_W      = 32;
    localparam int          FETCH_CNT_W = 16;
    localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;

    // Contents of one inter-stage pipeline register slot.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register slot with flush (clear to bubble) and enable
// (hold when low). Flush wins over a held enable so a redirect can always
// squash the slot, even during a stall.
module if_id_reg
    import arm_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   en,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t slot_d;
    if_id_t slot_q;

    // Next slot contents: flush > hold > load.
    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d = '0;
        end else if (en) begin
            slot_d = d;
        end
    end

    // Slot storage, cleared to a bubble on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q = slot_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter, combinational instruction memory addressing,
// IF/ID register and a saturating count of delivered instructions.
module fetch_stage
    import arm_pkg::*;
#(
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [WORD_W-1:0]      branch_addr,
    output logic [WORD_W-1:0]      imem_addr,
    input  logic [WORD_W-1:0]      imem_instr,
    output logic [WORD_W-1:0]      pc_out,
    output logic [WORD_W-1:0]      instr_out,
    output logic                   valid_out,
    output logic [FETCH_CNT_W-1:0] fetch_count
);

    localparam logic [WORD_W-1:0] PC_LIMIT = WORD_W'(IMEM_WORDS * 4);

    function automatic logic [FETCH_CNT_W-1:0] sat_inc(input logic [FETCH_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [WORD_W-1:0]      pc_d, pc_q;
    logic [FETCH_CNT_W-1:0] cnt_d, cnt_q;
    logic [WORD_W-1:0]      pc_plus4;
    logic                   in_range;
    if_id_t                 if_id_d, if_id_q;
    logic                   unused_addr_lsbs;

    assign pc_plus4  = pc_q + 32'd4;
    assign in_range  = (pc_q < PC_LIMIT);
    assign imem_addr = pc_q;

    // Branch bits [1:0] are deliberately discarded to force word alignment.
    assign unused_addr_lsbs = ^branch_addr[1:0];

    // Next PC: redirect beats stall; sequential fetch wraps only when it
    // lands exactly on the limit, so an out-of-range PC keeps climbing.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = {branch_addr[WORD_W-1:2], 2'b00};
        end else if (!freeze) begin
            pc_d = (pc_plus4 == PC_LIMIT) ? '0 : pc_plus4;
        end
    end

    // Count only real instructions entering ID on an unstalled, unflushed edge.
    always_comb begin
        cnt_d = cnt_q;
        if (!branch_taken && !freeze && in_range) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // IF/ID payload: out-of-range fetches become bubbles carrying a NOP.
    always_comb begin
        if_id_d.pc    = pc_plus4;
        if_id_d.instr = in_range ? imem_instr : INSTR_NOP;
        if_id_d.valid = in_range;
    end

    // PC and fetch counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (branch_taken),
        .en    (!freeze),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign pc_out      = if_id_q.pc;
    assign instr_out   = if_id_q.instr;
    assign valid_out   = if_id_q.valid;
    assign fetch_count = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage control for the ARM pipeline: owns the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction into the IF/ID pipeline register.
- Handles hazard freeze from the hazard unit and branch redirect/flush from EXE.
- Sits between the instruction memory (consumer of imem_addr, producer of imem_instr) and the ID stage (consumer of the IF/ID outputs).

Parameters:
- IMEM_WORDS, 64: instruction memory depth in 32-bit words. Byte address limit is IMEM_WORDS*4.
- RESET_PC, 32'h0000_0000: PC value after reset. Must be word aligned.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- freeze  input  1  hazard stall. Hold PC and the IF/ID register.
- branch_taken  input  1  redirect request from EXE.
- branch_addr  input  32  byte target of the redirect.
- imem_addr  output  32  byte address to the instruction memory. Combinational copy of the PC.
- imem_instr  input  32  instruction word returned combinationally by memory in the same cycle.
- pc_out  output  32  IF/ID register: fetched PC + 4.
- instr_out  output  32  IF/ID register: fetched instruction.
- valid_out  output  1  IF/ID register: instr_out is a real instruction; 0 means bubble.
- fetch_count  output  16  number of valid instructions delivered to ID. Saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; pc_out = 0; instr_out = 0; valid_out = 0; fetch_count = 0.
  - Applies immediately, including mid-freeze or mid-branch. First fetch happens at the first rising edge after rst_n rises.
- imem_addr = pc at all times, with no register. Memory read latency is 0 cycles, so imem_instr belongs to the current pc.
- in_range = (pc < IMEM_WORDS*4).
- Priority each rising edge: branch_taken > freeze > normal.
- branch_taken=1 (freeze is ignored):
  - pc <= {branch_addr[31:2], 2'b00}; misaligned low bits are dropped.
  - IF/ID flushed: instr_out <= 0, valid_out <= 0, pc_out <= 0.
  - fetch_count unchanged.
- freeze=1, branch_taken=0:
  - pc, pc_out, instr_out, valid_out and fetch_count all hold.
- Normal (neither asserted):
  - pc <= pc+4. If pc+4 == IMEM_WORDS*4, pc wraps to 0.
  - pc_out <= pc+4 (unwrapped value); instr_out <= imem_instr.
  - valid_out <= in_range.
  - fetch_count increments (saturating) when in_range=1.
- Out-of-range PC:
  - Reachable only via branch. Produces a bubble (valid_out=0, instr_out <= 0).
  - pc then increments without wrapping, since it is already past the limit; it stays out of range until the next branch or reset.
- Latency: one cycle from pc to the IF/ID outputs. Throughput: one instruction per unfrozen cycle.
- No X propagation: every register is reset, and imem_instr is never sampled while frozen.

Decomposition:
- Shared package arm_pkg holds:
  - WORD_W=32, INSTR_NOP=32'h0, FETCH_CNT_W=16.
  - A typedef for the IF/ID bundle: pc, instr, valid.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with flush (clear) and freeze (enable) inputs. ID-stage integration reuses it for ID/EXE.
- fetch_stage instantiates if_id_reg and contains the PC logic and fetch_count.

Test Plan:
- Reset then release, freeze=0, memory holding words W0..W3:
  - Edge 1: pc_out=4, instr_out=W0, valid_out=1, fetch_count=1.
  - Edge 4: pc_out=16, instr_out=W3, fetch_count=4.
  - imem_addr sequence: 0, 4, 8, 12, 16.
- freeze=1 for 3 cycles at pc=8:
  - imem_addr stays 8; pc_out, instr_out, valid_out and fetch_count all hold.
  - After release, the next edge delivers instr at 8 with pc_out=12.
- branch_taken=1, branch_addr=32'h23, with freeze=1 in the same cycle:
  - Next edge: pc=32'h20, valid_out=0, instr_out=0, fetch_count unchanged.
  - Following edge: instr at 0x20 delivered with pc_out=0x24.
- IMEM_WORDS=4, run 5 edges from reset:
  - imem_addr = 0, 4, 8, 12, 0.
  - pc_out on edge 4 is 16 (unwrapped).
- Branch to 32'h100 with IMEM_WORDS=64:
  - The next fetches are bubbles (valid_out=0) and fetch_count stays constant.
  - A branch to 0 restores valid fetches.
- Assert rst_n low between clock edges mid-run, with fetch_count=7 and pc=0x1C:
  - Outputs clear immediately (asynchronously): imem_addr=0, valid_out=0, fetch_count=0.
